// File: rtl/aclint_memory_if.sv
// Data-bus request/response channel between the core and the ACLINT.
interface aclint_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/aclint_memory.sv
// Single-hart ACLINT: MSWI (msip) and MTIMER (mtime, mtimecmp) behind the data bus.
module aclint_memory #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV    = 1,
    parameter logic [63:0] MTIME_RESET = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    aclint_memory_if.slave   bus,
    output logic             mtip,
    output logic             msip,
    output logic [63:0]      mtime
);
    // Word indices (offset[15:3]) of the mapped registers.
    localparam logic [12:0] OffMsip     = 13'h0000;
    localparam logic [12:0] OffMtimecmp = 13'h0800;
    localparam logic [12:0] OffMtime    = 13'h17FF;
    localparam logic [31:0] TickLast    = 32'(TICK_DIV - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] presc_q, presc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;

    logic [63:0] offset;
    logic [12:0] word;
    logic [63:0] mask64;
    logic [63:0] rdata_sel;
    logic        accept;
    logic        do_write;
    logic        unused_offset;

    // The window is 64 KiB aligned, so only offset[15:3] selects a register.
    assign offset        = bus.req_addr - BASE_ADDR;
    assign word          = offset[15:3];
    assign unused_offset = ^{offset[63:16], offset[2:0]};

    assign bus.req_ready = rst;
    assign accept        = bus.req_valid & bus.req_ready;
    // A write with an all-zero mask is a pure no-op apart from its response.
    assign do_write      = accept & bus.req_wen & (|bus.req_wmask);

    // Expand byte enables to a bit mask.
    always_comb begin
        mask64 = '0;
        for (int b = 0; b < 8; b++) begin
            mask64[8*b +: 8] = {8{bus.req_wmask[b]}};
        end
    end

    // Read mux: current (pre-write) register value at the addressed word.
    always_comb begin
        rdata_sel = '0;
        case (word)
            OffMsip:     rdata_sel = {63'b0, msip_q};
            OffMtimecmp: rdata_sel = mtimecmp_q;
            OffMtime:    rdata_sel = mtime_q;
            default:     rdata_sel = '0;
        endcase
    end

    // Next-state: prescaler/mtime tick, byte-merged writes, registered response.
    always_comb begin
        presc_d      = (presc_q == TickLast) ? 32'd0 : presc_q + 32'd1;
        mtime_d      = (presc_q == TickLast) ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d   = mtimecmp_q;
        msip_d       = msip_q;
        resp_valid_d = accept;
        resp_rdata_d = (accept && !bus.req_wen) ? rdata_sel : 64'd0;
        if (do_write) begin
            case (word)
                OffMsip: begin
                    if (bus.req_wmask[0]) msip_d = bus.req_wdata[0];
                end
                OffMtimecmp: begin
                    mtimecmp_d = (mtimecmp_q & ~mask64) | (bus.req_wdata & mask64);
                end
                OffMtime: begin
                    // Software write wins over a coincident tick and restarts the period.
                    mtime_d = (mtime_q & ~mask64) | (bus.req_wdata & mask64);
                    presc_d = 32'd0;
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q      <= MTIME_RESET;
            mtimecmp_q   <= '1;
            msip_q       <= 1'b0;
            presc_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            presc_q      <= presc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mtip           = (mtime_q >= mtimecmp_q);
    assign msip           = msip_q;
    assign mtime          = mtime_q;
endmodule

// File: tb/tb_aclint_memory.sv
// Bench for aclint_memory: two instances (TICK_DIV 1 and 4) against a time-based model.
module tb_aclint_memory;
    localparam logic [63:0] Base = 64'h0000_0000_0200_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aclint_memory_if ifa ();
    aclint_memory_if ifb ();
    logic        mtip_a, msip_a, mtip_b, msip_b;
    logic [63:0] mtime_a, mtime_b;

    aclint_memory #(.BASE_ADDR(Base), .TICK_DIV(1), .MTIME_RESET(64'd0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .mtip(mtip_a), .msip(msip_a), .mtime(mtime_a)
    );
    aclint_memory #(.BASE_ADDR(Base), .TICK_DIV(4), .MTIME_RESET(64'd0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .mtip(mtip_b), .msip(msip_b), .mtime(mtime_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: mtime = value last loaded + elapsed edges / divider.
    int unsigned div [2] = '{1, 4};
    logic [63:0] m_base [2];
    longint      m_bcyc [2];
    longint      m_cyc  [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic        m_rv   [2];
    logic [63:0] m_rd   [2];

    function automatic logic [63:0] m_time(int i);
        return m_base[i] + 64'((m_cyc[i] - m_bcyc[i]) / longint'(div[i]));
    endfunction

    function automatic logic [63:0] mrg(logic [63:0] old, logic [63:0] wd, logic [7:0] wm);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{wm[b]}};
        return (old & ~m) | (wd & m);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_base[i] <= 64'd0; m_bcyc[i] <= 0; m_cyc[i] <= 0;
                m_cmp[i] <= '1; m_msip[i] <= 1'b0; m_rv[i] <= 1'b0; m_rd[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic        v, w;
                logic [63:0] a, wd, off, cur, val;
                logic [7:0]  wm;
                v  = (i == 0) ? ifa.req_valid : ifb.req_valid;
                w  = (i == 0) ? ifa.req_wen   : ifb.req_wen;
                a  = (i == 0) ? ifa.req_addr  : ifb.req_addr;
                wd = (i == 0) ? ifa.req_wdata : ifb.req_wdata;
                wm = (i == 0) ? ifa.req_wmask : ifb.req_wmask;
                cur = m_time(i);
                off = (a - Base) & ~64'h7;
                val = 64'd0;
                if (off == 64'h0)         val = {63'b0, m_msip[i]};
                else if (off == 64'h4000) val = m_cmp[i];
                else if (off == 64'hBFF8) val = cur;
                m_rv[i] <= v;
                m_rd[i] <= (v && !w) ? val : 64'd0;
                if (v && w && wm != 8'h0) begin
                    if (off == 64'h0 && wm[0]) m_msip[i] <= wd[0];
                    if (off == 64'h4000)       m_cmp[i] <= mrg(m_cmp[i], wd, wm);
                    if (off == 64'hBFF8) begin
                        m_base[i] <= mrg(cur, wd, wm);
                        m_bcyc[i] <= m_cyc[i] + 1;
                    end
                end
                m_cyc[i] <= m_cyc[i] + 1;
            end
        end
    end

    // Compare every cycle on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        rdy, rv, tp, sp;
            logic [63:0] rd, mt;
            rdy = (i == 0) ? ifa.req_ready  : ifb.req_ready;
            rv  = (i == 0) ? ifa.resp_valid : ifb.resp_valid;
            rd  = (i == 0) ? ifa.resp_rdata : ifb.resp_rdata;
            mt  = (i == 0) ? mtime_a : mtime_b;
            tp  = (i == 0) ? mtip_a : mtip_b;
            sp  = (i == 0) ? msip_a : msip_b;
            chk($sformatf("i%0d.req_ready", i), {63'b0, rdy}, {63'b0, rst});
            chk($sformatf("i%0d.resp_valid", i), {63'b0, rv}, {63'b0, m_rv[i]});
            if (m_rv[i]) chk($sformatf("i%0d.resp_rdata", i), rd, m_rd[i]);
            chk($sformatf("i%0d.mtime", i), mt, m_time(i));
            chk($sformatf("i%0d.mtip", i), {63'b0, tp}, {63'b0, m_time(i) >= m_cmp[i]});
            chk($sformatf("i%0d.msip", i), {63'b0, sp}, {63'b0, m_msip[i]});
        end
    end

    // One-cycle request on instance i; returns #1 after the accepting edge.
    task automatic req(int i, bit w, logic [63:0] off, logic [63:0] wd, logic [7:0] wm);
        if (i == 0) begin
            ifa.req_valid = 1'b1; ifa.req_wen = w; ifa.req_addr = Base + off;
            ifa.req_wdata = wd; ifa.req_wmask = wm;
        end else begin
            ifb.req_valid = 1'b1; ifb.req_wen = w; ifb.req_addr = Base + off;
            ifb.req_wdata = wd; ifb.req_wmask = wm;
        end
        @(posedge clk); #1;
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
    endtask

    task automatic rd(int i, logic [63:0] off, output logic [63:0] d);
        req(i, 1'b0, off, 64'd0, 8'h00);
        d = (i == 0) ? ifa.resp_rdata : ifb.resp_rdata;
        chk("rd_resp_valid", {63'b0, (i == 0) ? ifa.resp_valid : ifb.resp_valid}, 64'd1);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] d;
        int k;
        ifa.req_valid = 0; ifa.req_wen = 0; ifa.req_addr = 0; ifa.req_wdata = 0; ifa.req_wmask = 0;
        ifb.req_valid = 0; ifb.req_wen = 0; ifb.req_addr = 0; ifb.req_wdata = 0; ifb.req_wmask = 0;
        step(2);
        rst = 1'b1;
        step(10);
        chk("idle_mtime_a", mtime_a, 64'd10);
        chk("idle_mtime_b", mtime_b, 64'd2);
        chk("idle_mtip_a", {63'b0, mtip_a}, 64'd0);
        chk("idle_msip_a", {63'b0, msip_a}, 64'd0);
        rd(0, 64'hBFF8, d);
        chk("read_mtime", d, 64'd10);

        // Timer compare rising and clearing.
        req(0, 1'b1, 64'hBFF8, 64'd5, 8'hFF);
        chk("mtime_load5", mtime_a, 64'd5);
        req(0, 1'b1, 64'h4000, 64'd20, 8'hFF);
        k = 0;
        while (mtime_a != 64'd20 && k < 40) begin
            step(1);
            k++;
        end
        chk("mtime_reach20", mtime_a, 64'd20);
        chk("mtip_at_20", {63'b0, mtip_a}, 64'd1);
        req(0, 1'b1, 64'h4000, '1, 8'hFF);
        chk("mtip_cleared", {63'b0, mtip_a}, 64'd0);

        // Software interrupt.
        req(0, 1'b1, 64'h0, 64'h3, 8'h01);
        chk("msip_set", {63'b0, msip_a}, 64'd1);
        rd(0, 64'h0, d);
        chk("msip_read", d, 64'd1);
        req(0, 1'b1, 64'h0, 64'h0, 8'h01);
        chk("msip_clr", {63'b0, msip_a}, 64'd0);

        // mtime wrap.
        req(0, 1'b1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        step(1);
        chk("wrap_ff", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_ff_mtip", {63'b0, mtip_a}, 64'd1);
        step(1);
        chk("wrap_zero", mtime_a, 64'd0);
        chk("wrap_zero_mtip", {63'b0, mtip_a}, 64'd0);

        // Partial and empty-mask writes to MTIMECMP.
        req(0, 1'b1, 64'h4000, 64'h1111_2222_3333_4444, 8'hFF);
        req(0, 1'b1, 64'h4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        rd(0, 64'h4000, d);
        chk("cmp_partial", d, 64'h1111_2222_CCCC_DDDD);
        req(0, 1'b1, 64'h4000, 64'h0, 8'h00);
        rd(0, 64'h4000, d);
        chk("cmp_mask0", d, 64'h1111_2222_CCCC_DDDD);

        // Divided timer instance.
        rd(1, 64'h8000, d);
        chk("unmapped_read", d, 64'd0);
        step(1);
        req(1, 1'b1, 64'hBFF8, 64'd100, 8'hFF);
        chk("div_load", mtime_b, 64'd100);
        step(3);
        chk("div_hold", mtime_b, 64'd100);
        step(1);
        chk("div_tick", mtime_b, 64'd101);

        // Reset while a read response is pending.
        ifb.req_valid = 1'b1; ifb.req_wen = 1'b0; ifb.req_addr = Base + 64'hBFF8;
        ifb.req_wmask = 8'h00;
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", {63'b0, ifb.resp_valid}, 64'd0);
        chk("rst_mtime_b", mtime_b, 64'd0);
        chk("rst_mtime_a", mtime_a, 64'd0);
        step(1);
        rst = 1'b1;
        step(3);
        chk("post_rst_resp", {63'b0, ifb.resp_valid}, 64'd0);
        chk("post_rst_mtime_a", mtime_a, 64'd3);
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
